// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: 3-stage nibble-tiled approximate multiplier.
// Modes: 0 exact, 1 OR of tiles, 2 drop low tiles, 3 OR-low/add-high.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand handshake for a, b, mode
//   out_valid/out_ready   result handshake for r
//   op_count              accepted results, wraps at 2^16
module approx_mult_pipe #(
  parameter int W        = 8,
  parameter int DROP_LVL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [1:0]      mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  r,
  output logic [15:0]     op_count
);

  localparam int N  = W / 4;
  localparam int RW = 2 * W;

  logic          en;

  logic          s1_v;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;
  logic [1:0]    s1_mode;

  logic          s2_v;
  logic [1:0]    s2_mode;
  logic [7:0]    s2_p [N][N];
  logic [7:0]    p_d  [N][N];

  logic [RW-1:0] tile;
  logic [RW-1:0] sum_all;
  logic [RW-1:0] or_all;
  logic [RW-1:0] sum_tr;
  logic [RW-1:0] lo_or;
  logic [RW-1:0] hi_sum;
  logic [RW-1:0] r_d;

  logic          v_q;
  logic [RW-1:0] r_q;
  logic [15:0]   cnt_q;

  // whole pipe advances together; bubbles are not squeezed
  assign en        = !v_q || out_ready;
  assign in_ready  = en;
  assign out_valid = v_q;
  assign r         = r_q;
  assign op_count  = cnt_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        p_d[i][j] = {4'h0, s1_a[4*i +: 4]}
                  * {4'h0, s1_b[4*j +: 4]};
      end
    end
  end

  always_comb begin
    tile    = '0;
    sum_all = '0;
    or_all  = '0;
    sum_tr  = '0;
    lo_or   = '0;
    hi_sum  = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        tile    = RW'(s2_p[i][j]) << (4 * (i + j));
        sum_all = sum_all + tile;
        or_all  = or_all | tile;
        if (i + j >= DROP_LVL) begin
          sum_tr = sum_tr + tile;
        end
        // low diagonals compress by OR, high ones stay exact
        if (i + j < N) begin
          lo_or = lo_or | tile;
        end else begin
          hi_sum = hi_sum + tile;
        end
      end
    end
  end

  always_comb begin
    unique case (s2_mode)
      2'd0:    r_d = sum_all;
      2'd1:    r_d = or_all;
      2'd2:    r_d = sum_tr;
      default: r_d = lo_or + hi_sum;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_mode <= '0;
      s2_v    <= 1'b0;
      s2_mode <= '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          s2_p[i][j] <= '0;
        end
      end
      v_q     <= 1'b0;
      r_q     <= '0;
    end else if (en) begin
      s1_v    <= in_valid;
      s1_a    <= a;
      s1_b    <= b;
      s1_mode <= mode;
      s2_v    <= s1_v;
      s2_mode <= s1_mode;
      s2_p    <= p_d;
      v_q     <= s2_v;
      r_q     <= r_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (v_q && out_ready) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: doc/approx_mult_pipe.md
# approx_mult_pipe

Parametrised, pipelined approximate multiplier for the 8x8 multiplier library. It splits each W-bit operand into 4-bit nibbles and forms every 4x4 tile product. A per-transaction mode selects how the tiles are combined: exact sum, full OR-compression, low-tile truncation, or a hybrid OR/add. The block sits behind a valid/ready handshake so it can be dropped into streaming accuracy-evaluation and datapath benches without an external wrapper.

## Interface
- W, 8: operand width; multiple of 4, legal range 8..16.
- DROP_LVL, 1: mode-2 truncation level; tiles with i+j < DROP_LVL are dropped. Legal range 0..2*(W/4)-1.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  W  unsigned multiplicand.
- b  in  W  unsigned multiplier.
- mode  in  2  combine mode, captured with the operands.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- r  out  2W  result.
- op_count  out  16  number of results accepted downstream; wraps at 2^16.

## Operation
- Tiles: N = W/4. A nibble i = a[4i+3:4i], B nibble j = b[4j+3:4j], for i,j in 0..N-1. P_ij = exact 8-bit product A_i*B_j. S_ij = P_ij << 4(i+j), zero-extended to 2W bits.
- mode 0 (exact): r = sum of all S_ij, which equals a*b.
- mode 1 (OR): r = bitwise OR of all S_ij.
- mode 2 (truncate): r = sum of S_ij over tiles with i+j >= DROP_LVL. With DROP_LVL=0, this equals mode 0.
- mode 3 (hybrid): L = OR of S_ij with i+j < N; H = sum of S_ij with i+j >= N; r = (L + H) mod 2^(2W).
- All sums are unsigned and truncated to 2W bits. Overflow cannot occur in mode 0.
- Pipeline stages:
  - S1 registers a, b, mode, valid.
  - S2 registers all N^2 P_ij plus mode and valid.
  - S3 combines the tiles and registers r and out_valid.
- Stall control: en = !out_valid || out_ready. in_ready = en.
  - When en = 1, all stages shift by one and accept the new input beat (valid = in_valid && in_ready).
  - When en = 0, every stage holds, including r and out_valid.
- Bubbles are not squeezed. An empty stage still waits for en to be asserted.
- op_count increments on every cycle where out_valid && out_ready. It wraps 0xFFFF -> 0x0000.

## Timing
- Reset (rst_n low at an edge): all stage valids become 0, out_valid = 0, r = 0, op_count = 0, and stage data registers are cleared to 0. in_ready reads 1 on the cycle after reset.
- Reset mid-operation discards all in-flight beats. No result for those beats ever appears.
- Latency: a beat accepted at edge k appears with out_valid = 1 after edge k+2, i.e. three registers. With out_ready held high, throughput is 1 beat per cycle.
- in_ready is combinational from out_valid and out_ready. No other path from in_* to out_* is combinational.
- When out_valid = 1 and out_ready = 0:
  - r holds stable and in_ready = 0.
  - A beat presented with in_valid while in_ready = 0 is not taken.
- In a cycle where a result is accepted and a new beat is accepted together, both happen. op_count increments and the pipeline shifts.
- mode is sampled only with its beat. Changing mode between beats has no effect on beats already in flight.

## Test plan
- W=8, DROP_LVL=1, out_ready=1, a=0x12, b=0x34, one beat per mode 0/1/2/3. Required r after 3 cycles each: 0x03A8, 0x0368, 0x03A0, 0x0368. op_count ends at 4.
- W=8, a=b=0xFF, modes 0/1/2/3. Required r: 0xFE01, 0xEFF1, 0xFD20, 0xEFF1.
- Back-pressure: stream 6 beats with mode 0, a=n, b=n+1 (n=1..6), and hold out_ready=0 for 4 cycles mid-stream. Required: r holds, in_ready=0 during the hold, all 6 results arrive in order with r = n(n+1), none lost or duplicated, op_count=6.
- Reset mid-stream: accept 2 beats, assert rst_n=0 for one edge. Required: out_valid=0, r=0, op_count=0 next cycle, and no stale result afterwards.
- W=16, DROP_LVL=0, random a and b, 1000 beats, random modes and random out_ready. A reference model using the tile equations above must match every r. Mode 2 must equal mode 0.
- op_count wrap: preload by streaming 65536 accepted results. Required: op_count returns to 0x0000.
